fb_update_seq: RTL and testbench
================================

FB_UPDATE_SEQ -- requirements
Module: fb_update_seq

Interface
REQ-001 Parameter BKG_W, default 320: background pixels copied per horizontal-blank line pass.
REQ-002 Parameter SPR_CNT, default 8: number of sprite slots drawn per vertical blank.
REQ-003 Parameters SPR_W and SPR_H, defaults 32 and 32: sprite width and height in pixels.
REQ-004 Parameter ADDR_W, default 11: width of the sprite-descriptor memory address.
REQ-005 Parameter SPR_BASE, default 50: descriptor address of sprite slot 0; slot i is at SPR_BASE+i.
REQ-006 Parameter RD_LAT, default 2, legal range 1..7: descriptor memory read latency in cycles.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 vblank  in  1  vertical blank level; starts the sprite pass.
REQ-010 hblank  in  1  horizontal blank level; starts a background line pass.
REQ-011 spr_valid  in  SPR_CNT  per-slot enable; bit i=0 means slot i is skipped.
REQ-012 mem_addr  out  ADDR_W  descriptor memory address; all-ones when unused.
REQ-013 mem_oe  out  1  descriptor memory read enable.
REQ-014 mem_we  out  4  byte write enables; constant 0.
REQ-015 bkg_en  out  1  background pixel strobe.
REQ-016 bkg_x  out  clog2(BKG_W)  background pixel column.
REQ-017 spr_en  out  1  sprite pixel strobe.
REQ-018 spr_idx, spr_x, spr_y  out  clog2(SPR_CNT), clog2(SPR_W), clog2(SPR_H)  current slot and in-sprite pixel coordinates.
REQ-019 busy  out  1  high in any state other than IDLE.
REQ-020 frame_done, spr_abort  out  1 each  single-cycle completion and abort pulses.

Function
REQ-021 States SHALL be IDLE, LINE, FETCH, DRAW, DONE; outputs SHALL be Moore, decoded from the registered state and counters.
REQ-022 In IDLE, vblank=1 SHALL enter FETCH with spr_idx=0; otherwise hblank=1 SHALL enter LINE; vblank SHALL win when both are high.
REQ-023 In LINE: mem_addr=0, mem_oe=1, bkg_en=1, bkg_x SHALL step 0..BKG_W-1 one per cycle, then the state SHALL return to IDLE; a line pass SHALL always complete regardless of vblank/hblank.
REQ-024 In FETCH with spr_valid[spr_idx]=0: one cycle, no memory read, no draw; advance to the next slot.
REQ-025 In FETCH with spr_valid[spr_idx]=1: mem_addr=SPR_BASE+spr_idx (modulo 2^ADDR_W), mem_oe=1, for exactly RD_LAT cycles, then DRAW.
REQ-026 In DRAW: spr_en=1, mem_oe=1, mem_addr held; spr_x is the inner count 0..SPR_W-1 and spr_y the outer count 0..SPR_H-1; SPR_W*SPR_H cycles per sprite.
REQ-027 After the last pixel (or skip) of slot SPR_CNT-1, DONE SHALL be entered; otherwise FETCH with spr_idx+1.
REQ-028 frame_done SHALL pulse for the first DONE cycle only; DONE SHALL hold until vblank=0, then go to IDLE, so one vblank yields one sprite pass.
REQ-029 vblank=0 seen in FETCH or DRAW SHALL abort: spr_abort pulses for one cycle, next state IDLE, and all counters clear; frame_done SHALL NOT pulse.
REQ-030 hblank during FETCH, DRAW or DONE SHALL be ignored.
REQ-031 Outside the active states: mem_addr all-ones, mem_oe=0, bkg_en=0, spr_en=0, counters 0.

Reset
REQ-032 reset=1 at a rising edge SHALL, from any state including mid-pass, set IDLE and clear all counters, so that in the following cycle busy=0, frame_done=0, spr_abort=0, mem_oe=0, mem_addr all-ones, bkg_en=0, spr_en=0.
REQ-033 reset SHALL take priority over vblank and hblank in the same cycle.

Verification (BKG_W=4, SPR_CNT=2, SPR_W=2, SPR_H=2, RD_LAT=1, SPR_BASE=50)
REQ-034 Single-cycle hblank pulse from IDLE -> 4 cycles of bkg_en=1, bkg_x 0,1,2,3, mem_addr 0, then IDLE and busy=0.
REQ-035 vblank held, spr_valid=2'b11 -> 1 cycle at addr 50, then (x,y) = (0,0),(1,0),(0,1),(1,1); then 1 cycle at addr 51, then the same 4 pixels; then one frame_done pulse; DONE held until vblank drops, then IDLE.
REQ-036 spr_valid=2'b10 -> slot 0 takes a 1-cycle skip with mem_oe=0, and only slot 1 is drawn.
REQ-037 vblank and hblank rise in the same cycle in IDLE -> FETCH entered and no bkg_en strobe.
REQ-038 vblank drops during the third DRAW pixel -> spr_abort pulses once, IDLE, no frame_done.
REQ-039 reset asserted mid-DRAW and mid-LINE -> all outputs at their reset values in the following cycle.

Source files
------------

// File: rtl/fb_update_seq.sv
// Frame-buffer update sequencer: copies one background line per hblank and
// draws the enabled sprite slots once per vblank, fetching each descriptor first.
module fb_update_seq #(
  parameter int BKG_W    = 320,
  parameter int SPR_CNT  = 8,
  parameter int SPR_W    = 32,
  parameter int SPR_H    = 32,
  parameter int ADDR_W   = 11,
  parameter int SPR_BASE = 50,
  parameter int RD_LAT   = 2,
  localparam int BXW = (BKG_W   > 1) ? $clog2(BKG_W)   : 1,
  localparam int IW  = (SPR_CNT > 1) ? $clog2(SPR_CNT) : 1,
  localparam int XW  = (SPR_W   > 1) ? $clog2(SPR_W)   : 1,
  localparam int YW  = (SPR_H   > 1) ? $clog2(SPR_H)   : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vblank,
  input  logic               hblank,
  input  logic [SPR_CNT-1:0] spr_valid,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_oe,
  output logic [3:0]         mem_we,
  output logic               bkg_en,
  output logic [BXW-1:0]     bkg_x,
  output logic               spr_en,
  output logic [IW-1:0]      spr_idx,
  output logic [XW-1:0]      spr_x,
  output logic [YW-1:0]      spr_y,
  output logic               busy,
  output logic               frame_done,
  output logic               spr_abort
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LINE  = 3'd1,
    FETCH = 3'd2,
    DRAW  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [BXW-1:0] BX_LAST  = BXW'(BKG_W - 1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(SPR_CNT - 1);
  localparam logic [XW-1:0]  PX_LAST  = XW'(SPR_W - 1);
  localparam logic [YW-1:0]  PY_LAST  = YW'(SPR_H - 1);
  localparam logic [2:0]     LAT_LAST = 3'(RD_LAT - 1);

  state_t         state_reg, state_next;
  logic [BXW-1:0] bx_reg, bx_next;
  logic [IW-1:0]  idx_reg, idx_next;
  logic [XW-1:0]  px_reg, px_next;
  logic [YW-1:0]  py_reg, py_next;
  logic [2:0]     lat_reg, lat_next;
  logic           slot_on_reg, slot_on_next;
  logic           frame_done_reg, frame_done_next;
  logic           abort_reg, abort_next;
  logic           slot_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      bx_reg         <= '0;
      idx_reg        <= '0;
      px_reg         <= '0;
      py_reg         <= '0;
      lat_reg        <= '0;
      slot_on_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      abort_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bx_reg         <= bx_next;
      idx_reg        <= idx_next;
      px_reg         <= px_next;
      py_reg         <= py_next;
      lat_reg        <= lat_next;
      slot_on_reg    <= slot_on_next;
      frame_done_reg <= frame_done_next;
      abort_reg      <= abort_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    bx_next    = bx_reg;
    idx_next   = idx_reg;
    px_next    = px_reg;
    py_next    = py_reg;
    lat_next   = lat_reg;
    abort_next = 1'b0;
    slot_end   = 1'b0;

    case (state_reg)
      IDLE: begin
        bx_next  = '0;
        idx_next = '0;
        px_next  = '0;
        py_next  = '0;
        lat_next = '0;
        if (vblank)
          state_next = FETCH;
        else if (hblank)
          state_next = LINE;
      end

      // A line pass is never interrupted by the blanking inputs.
      LINE: begin
        if (bx_reg == BX_LAST) begin
          bx_next    = '0;
          state_next = IDLE;
        end else begin
          bx_next = bx_reg + 1'b1;
        end
      end

      FETCH: begin
        if (!vblank) begin
          abort_next = 1'b1;
        end else if (!slot_on_reg) begin
          slot_end = 1'b1;
        end else if (lat_reg == LAT_LAST) begin
          lat_next   = '0;
          state_next = DRAW;
        end else begin
          lat_next = lat_reg + 1'b1;
        end
      end

      DRAW: begin
        if (!vblank) begin
          abort_next = 1'b1;
        end else if (px_reg == PX_LAST) begin
          px_next = '0;
          if (py_reg == PY_LAST) begin
            py_next  = '0;
            slot_end = 1'b1;
          end else begin
            py_next = py_reg + 1'b1;
          end
        end else begin
          px_next = px_reg + 1'b1;
        end
      end

      DONE: begin
        if (!vblank)
          state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase

    if (slot_end) begin
      lat_next = '0;
      if (idx_reg == IDX_LAST) begin
        idx_next   = '0;
        state_next = DONE;
      end else begin
        idx_next   = idx_reg + 1'b1;
        state_next = FETCH;
      end
    end

    if (abort_next) begin
      state_next = IDLE;
      bx_next    = '0;
      idx_next   = '0;
      px_next    = '0;
      py_next    = '0;
      lat_next   = '0;
    end
  end

  // Slot enable is captured on entry to FETCH so outputs depend only on registers.
  assign slot_on_next    = (state_next == FETCH) ? spr_valid[idx_next] : 1'b0;
  assign frame_done_next = (state_next == DONE) && (state_reg != DONE);

  logic [ADDR_W-1:0] slot_addr;
  assign slot_addr = ADDR_W'(SPR_BASE) + ADDR_W'(idx_reg);

  always_comb begin
    mem_addr = '1;
    mem_oe   = 1'b0;
    bkg_en   = 1'b0;
    spr_en   = 1'b0;
    case (state_reg)
      LINE: begin
        mem_addr = '0;
        mem_oe   = 1'b1;
        bkg_en   = 1'b1;
      end
      FETCH: begin
        if (slot_on_reg) begin
          mem_addr = slot_addr;
          mem_oe   = 1'b1;
        end
      end
      DRAW: begin
        mem_addr = slot_addr;
        mem_oe   = 1'b1;
        spr_en   = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_we     = 4'b0000;
  assign bkg_x      = bx_reg;
  assign spr_idx    = idx_reg;
  assign spr_x      = px_reg;
  assign spr_y      = py_reg;
  assign busy       = (state_reg != IDLE);
  assign frame_done = frame_done_reg;
  assign spr_abort  = abort_reg;

endmodule

// File: tb/tb_fb_update_seq.sv
// Directed bench for fb_update_seq: expected per-cycle outputs are queued with
// the stimulus and compared one entry per clock at the falling edge.
module tb_fb_update_seq;

  logic        clk;
  logic        reset;
  logic        vblank;
  logic        hblank;
  logic [1:0]  spr_valid;
  logic [10:0] mem_addr;
  logic        mem_oe;
  logic [3:0]  mem_we;
  logic        bkg_en;
  logic [1:0]  bkg_x;
  logic        spr_en;
  logic [0:0]  spr_idx;
  logic [0:0]  spr_x;
  logic [0:0]  spr_y;
  logic        busy;
  logic        frame_done;
  logic        spr_abort;

  int checks = 0;
  int errors = 0;

  logic [25:0] exp_q[$];
  string       tag_q[$];

  fb_update_seq #(
    .BKG_W(4), .SPR_CNT(2), .SPR_W(2), .SPR_H(2),
    .ADDR_W(11), .SPR_BASE(50), .RD_LAT(1)
  ) dut (
    .clk(clk), .reset(reset), .vblank(vblank), .hblank(hblank),
    .spr_valid(spr_valid), .mem_addr(mem_addr), .mem_oe(mem_oe),
    .mem_we(mem_we), .bkg_en(bkg_en), .bkg_x(bkg_x), .spr_en(spr_en),
    .spr_idx(spr_idx), .spr_x(spr_x), .spr_y(spr_y), .busy(busy),
    .frame_done(frame_done), .spr_abort(spr_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed layout: busy, frame_done, spr_abort, mem_oe, mem_addr, bkg_en,
  // bkg_x, spr_en, spr_idx, spr_x, spr_y, mem_we.
  function automatic void push(input string t, input logic b, input logic fd,
                               input logic ab, input logic oe, input logic [10:0] a,
                               input logic be, input logic [1:0] bx, input logic se,
                               input logic si, input logic sx, input logic sy);
    exp_q.push_back({b, fd, ab, oe, a, be, bx, se, si, sx, sy, 4'b0000});
    tag_q.push_back(t);
  endfunction

  function automatic void push_idle(input string t, input logic ab);
    push(t, 1'b0, 1'b0, ab, 1'b0, 11'h7FF, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic void push_line(input string t, input logic [1:0] x);
    push(t, 1'b1, 1'b0, 1'b0, 1'b1, 11'd0, 1'b1, x, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic void push_fetch(input string t, input logic idx);
    push(t, 1'b1, 1'b0, 1'b0, 1'b1, 11'd50 + {10'd0, idx}, 1'b0, 2'd0, 1'b0, idx, 1'b0, 1'b0);
  endfunction

  function automatic void push_skip(input string t, input logic idx);
    push(t, 1'b1, 1'b0, 1'b0, 1'b0, 11'h7FF, 1'b0, 2'd0, 1'b0, idx, 1'b0, 1'b0);
  endfunction

  function automatic void push_draw(input string t, input logic idx, input logic x, input logic y);
    push(t, 1'b1, 1'b0, 1'b0, 1'b1, 11'd50 + {10'd0, idx}, 1'b0, 2'd0, 1'b1, idx, x, y);
  endfunction

  function automatic void push_sprite(input string t, input logic idx);
    push_draw(t, idx, 1'b0, 1'b0);
    push_draw(t, idx, 1'b1, 1'b0);
    push_draw(t, idx, 1'b0, 1'b1);
    push_draw(t, idx, 1'b1, 1'b1);
  endfunction

  function automatic void push_done(input string t, input logic fd);
    push(t, 1'b1, fd, 1'b0, 1'b0, 11'h7FF, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // Advance one clock and compare the outputs against the next queued entry.
  task automatic tick();
    logic [25:0] obs;
    logic [25:0] expv;
    string       t;
    @(posedge clk);
    @(negedge clk);
    obs = {busy, frame_done, spr_abort, mem_oe, mem_addr, bkg_en, bkg_x,
           spr_en, spr_idx, spr_x, spr_y, mem_we};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL underflow observed=%h required=<queued entry>", obs);
    end else begin
      expv = exp_q.pop_front();
      t    = tag_q.pop_front();
      assert (obs === expv) else begin
        errors++;
        $error("FAIL %s observed=%h required=%h", t, obs, expv);
      end
      $display("cycle %s observed=%h required=%h", t, obs, expv);
    end
  endtask

  initial begin
    reset     = 1'b1;
    vblank    = 1'b0;
    hblank    = 1'b0;
    spr_valid = 2'b00;

    push_idle("reset", 1'b0);
    tick();
    reset = 1'b0;
    push_idle("idle", 1'b0);
    tick();

    // Background line from a one-cycle hblank pulse.
    hblank = 1'b1;
    for (int i = 0; i < 4; i++) push_line("line", 2'(i));
    push_idle("line_end", 1'b0);
    tick();
    hblank = 1'b0;
    repeat (4) tick();

    // Full sprite pass, hblank ignored while in DONE.
    spr_valid = 2'b11;
    vblank    = 1'b1;
    push_fetch("fetch0", 1'b0);
    push_sprite("draw0", 1'b0);
    push_fetch("fetch1", 1'b1);
    push_sprite("draw1", 1'b1);
    push_done("done_pulse", 1'b1);
    push_done("done_hold", 1'b0);
    push_done("done_hold", 1'b0);
    push_idle("frame_idle", 1'b0);
    repeat (11) tick();
    hblank = 1'b1;
    tick();
    hblank = 1'b0;
    tick();
    vblank = 1'b0;
    tick();

    // Slot 0 disabled: one skip cycle, then slot 1 only.
    spr_valid = 2'b10;
    vblank    = 1'b1;
    push_skip("skip0", 1'b0);
    push_fetch("fetch1_only", 1'b1);
    push_sprite("draw1_only", 1'b1);
    push_done("done_skip", 1'b1);
    push_idle("skip_idle", 1'b0);
    repeat (7) tick();
    vblank = 1'b0;
    tick();

    // vblank wins over hblank; dropping vblank in FETCH aborts.
    spr_valid = 2'b11;
    vblank    = 1'b1;
    hblank    = 1'b1;
    push_fetch("both_fetch", 1'b0);
    push_idle("fetch_abort", 1'b1);
    push_idle("post_abort", 1'b0);
    tick();
    hblank = 1'b0;
    vblank = 1'b0;
    tick();
    tick();

    // Abort during the third pixel of slot 0.
    vblank = 1'b1;
    push_fetch("ab_fetch", 1'b0);
    push_draw("ab_draw", 1'b0, 1'b0, 1'b0);
    push_draw("ab_draw", 1'b0, 1'b1, 1'b0);
    push_draw("ab_draw3", 1'b0, 1'b0, 1'b1);
    push_idle("draw_abort", 1'b1);
    push_idle("draw_abort_end", 1'b0);
    repeat (4) tick();
    vblank = 1'b0;
    tick();
    tick();

    // Reset mid-DRAW with vblank still high.
    vblank = 1'b1;
    push_fetch("rd_fetch", 1'b0);
    push_draw("rd_draw", 1'b0, 1'b0, 1'b0);
    push_draw("rd_draw", 1'b0, 1'b1, 1'b0);
    push_idle("reset_draw", 1'b0);
    push_idle("reset_draw_rel", 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    vblank = 1'b0;
    tick();

    // Reset mid-LINE with hblank held high.
    hblank = 1'b1;
    push_line("rl_line", 2'd0);
    push_line("rl_line", 2'd1);
    push_idle("reset_line", 1'b0);
    push_idle("reset_line_rel", 1'b0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    hblank = 1'b0;
    tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover observed=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
